// File: rtl/inst_mem_loader_if.sv
// Stream-in / byte-write-out bus between a program source and the instruction memory loader.
interface inst_mem_loader_if #(
    parameter int unsigned Mbit = 32
);
    logic [Mbit-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            wr_en;
    logic [Mbit-1:0] wr_adr;
    logic [7:0]      wr_byte;

    // Host side: drives words, observes the memory write port.
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_adr, wr_byte
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_adr, wr_byte
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads 32-bit words into the big-endian byte-addressed instruction memory, holding the core in reset.
// Optional running word checksum output enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int unsigned Mbit = 32,
    parameter int unsigned size = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [Mbit-1:0] base_adr,
    input  logic [Mbit-1:0] word_count,
    inst_mem_loader_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            cpu_hold
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    output logic [Mbit-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        st_idle,
        st_wait,
        st_write,
        st_done,
        st_err
    } state_t;

    localparam logic [Mbit-1:0] last_adr = Mbit'(size - 1);

    state_t          state;
    logic [Mbit-1:0] ptr;
    logic [Mbit-1:0] rem;
    logic [1:0]      idx;
    logic [1:0]      nidx;
    logic [31:0]     wbuf;

    assign bus.in_ready = (state == st_wait);
    assign nidx         = idx + 2'd1;

    // Single-process FSM; every output except in_ready is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= st_idle;
            ptr         <= '0;
            rem         <= '0;
            idx         <= '0;
            wbuf        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_adr  <= '0;
            bus.wr_byte <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_hold    <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            case (state)
                st_idle, st_done, st_err: begin
                    if (start) begin
                        // Low address bits dropped so every word lands aligned.
                        ptr      <= base_adr & ~Mbit'(3);
                        rem      <= word_count;
                        err      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (word_count == '0) begin
                            state    <= st_done;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state    <= st_wait;
                            done     <= 1'b0;
                            cpu_hold <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                st_wait: begin
                    if (bus.in_valid) begin
                        if ((ptr + Mbit'(3)) > last_adr) begin
                            state <= st_err;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= st_write;
                            wbuf        <= bus.in_data[31:0];
                            idx         <= 2'd0;
                            bus.wr_en   <= 1'b1;
                            bus.wr_adr  <= ptr;
                            bus.wr_byte <= bus.in_data[31:24];
`ifdef INST_LOADER_CHECKSUM_EN
                            checksum    <= checksum + bus.in_data;
`endif
                        end
                    end
                end
                st_write: begin
                    if (idx == 2'd3) begin
                        bus.wr_en <= 1'b0;
                        ptr       <= ptr + Mbit'(4);
                        rem       <= rem - Mbit'(1);
                        if (rem == Mbit'(1)) begin
                            state    <= st_done;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= st_wait;
                        end
                    end else begin
                        // MSB first: byte idx comes from bits [31-8*idx -: 8].
                        idx         <= nidx;
                        bus.wr_adr  <= ptr + Mbit'(nidx);
                        bus.wr_byte <= 8'(wbuf >> {2'd3 - nidx, 3'b000});
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule
